// File: rtl/neopix_bank_ctrl_pkg.sv
// neopix_pkg: shared state encoding, sizing helper and frame RAM word layout
// for the neopix bank controller slice.
package neopix_pkg;
    typedef enum logic [1:0] {IDLE, WRITING, PENDING} state_t;
    localparam int NUM_LEDS_DEF = 8;
    localparam int WORD_W = 24;
    localparam int G_LSB  = 16;
    localparam int R_LSB  = 8;
    localparam int B_LSB  = 0;
    localparam int CH_W   = 8;
    function automatic int cnt_w(input int n);
        return $clog2(n) + 1;
    endfunction
endpackage

// File: rtl/neopix_bank_ctrl_if.sv
// neopix_bank_ctrl_if: SPI-writer / serializer side signals of the bank controller.
interface neopix_bank_ctrl_if #(
    parameter int CNT_W = neopix_pkg::cnt_w(neopix_pkg::NUM_LEDS_DEF),
    parameter int OVR_W = 8
);
    logic             wr_frame_start;
    logic             wr_frame_end;
    logic             wr_led_inc;
    logic             disp_latch;
    logic             wr_bank;
    logic             wr_allow;
    logic             rd_bank;
    logic [CNT_W-1:0] rd_count;
    logic             frame_pending;
    logic             swap_pulse;
    logic [OVR_W-1:0] ovr_count;
    modport master (
        output wr_frame_start, wr_frame_end, wr_led_inc, disp_latch,
        input  wr_bank, wr_allow, rd_bank, rd_count, frame_pending, swap_pulse, ovr_count
    );
    modport slave (
        input  wr_frame_start, wr_frame_end, wr_led_inc, disp_latch,
        output wr_bank, wr_allow, rd_bank, rd_count, frame_pending, swap_pulse, ovr_count
    );
endinterface

// File: rtl/neopix_bank_ctrl_sat_counter.sv
// neopix_sat_counter: saturating up-counter with synchronous clear (clear wins over inc).
module neopix_sat_counter #(
    parameter int           W   = 4,
    parameter logic [W-1:0] MAX = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] q_q, q_d;
    always_comb q_d = clr_i ? '0 : (inc_i && q_q != MAX) ? q_q + 1'b1 : q_q;
    always_ff @(posedge clk) q_q <= rst ? '0 : q_d;
    assign q_o = q_q;
endmodule

// File: rtl/neopix_bank_ctrl.sv
// neopix_bank_ctrl: double-buffered LED frame bank scheduler; swaps only in the latch gap.
// Optional idle blanking is built when NEOPIX_BLANK_TIMEOUT_EN is defined.
module neopix_bank_ctrl
    import neopix_pkg::*;
#(
    parameter int NUM_LEDS = NUM_LEDS_DEF,
    parameter int CNT_W    = cnt_w(NUM_LEDS),
    parameter int OVR_W    = 8
`ifdef NEOPIX_BLANK_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 50000000
`endif
) (
    input logic               CLK,
    input logic               RST,
    neopix_bank_ctrl_if.slave bus
);
    state_t           state_q, state_d;
    logic             rd_bank_q, rd_bank_d, wr_bank_q, wr_bank_d, swap_q, swap_d;
    logic [CNT_W-1:0] rd_count_q, rd_count_d, wr_cnt;
    logic [OVR_W-1:0] ovr;
    logic             start, blank;
    assign start = bus.wr_frame_start;
    neopix_sat_counter #(.W(CNT_W), .MAX(CNT_W'(NUM_LEDS))) u_wr_cnt (
        .clk(CLK), .rst(RST), .clr_i(start),
        .inc_i(bus.wr_led_inc && state_q == WRITING), .q_o(wr_cnt)
    );
    neopix_sat_counter #(.W(OVR_W)) u_ovr (
        .clk(CLK), .rst(RST), .clr_i(1'b0),
        .inc_i(start && state_q == PENDING), .q_o(ovr)
    );
`ifdef NEOPIX_BLANK_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo;
    neopix_sat_counter #(.W(TMO_W), .MAX(TMO_W'(TIMEOUT_CYCLES))) u_tmo (
        .clk(CLK), .rst(RST), .clr_i(swap_d), .inc_i(1'b1), .q_o(tmo)
    );
    assign blank = tmo == TMO_W'(TIMEOUT_CYCLES);
`else
    assign blank = 1'b0;
`endif
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            rd_bank_q  <= 1'b0;
            wr_bank_q  <= 1'b1;
            rd_count_q <= '0;
            swap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_bank_q  <= rd_bank_d;
            wr_bank_q  <= wr_bank_d;
            rd_count_q <= rd_count_d;
            swap_q     <= swap_d;
        end
    end
    // A new start always wins: it restarts, or drops a pending frame before it can swap.
    always_comb begin
        swap_d     = state_q == PENDING && bus.disp_latch && !start;
        state_d    = start ? WRITING
                   : (state_q == WRITING && bus.wr_frame_end) ? PENDING
                   : swap_d ? IDLE : state_q;
        rd_bank_d  = swap_d ? wr_bank_q : rd_bank_q;
        wr_bank_d  = swap_d ? rd_bank_q : wr_bank_q;
        rd_count_d = swap_d ? wr_cnt : rd_count_q;
    end
    assign bus.wr_bank       = wr_bank_q;
    assign bus.rd_bank       = rd_bank_q;
    assign bus.wr_allow      = state_q == WRITING;
    assign bus.frame_pending = state_q == PENDING;
    assign bus.swap_pulse    = swap_q;
    assign bus.rd_count      = blank ? '0 : rd_count_q;
    assign bus.ovr_count     = ovr;
endmodule

// File: tb/tb_neopix_bank_ctrl.sv
// tb_neopix_bank_ctrl: directed scenarios with hand-computed expectations for neopix_bank_ctrl.
module tb_neopix_bank_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    neopix_bank_ctrl_if #(.CNT_W(4), .OVR_W(8)) bus ();
`ifdef NEOPIX_BLANK_TIMEOUT_EN
    neopix_bank_ctrl #(.NUM_LEDS(8), .TIMEOUT_CYCLES(100)) dut (.CLK(clk), .RST(rst), .bus(bus));
`else
    neopix_bank_ctrl #(.NUM_LEDS(8)) dut (.CLK(clk), .RST(rst), .bus(bus));
`endif
    always #5 clk = ~clk;
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic pulse_start;
        bus.wr_frame_start = 1'b1; tick(); bus.wr_frame_start = 1'b0;
    endtask
    task automatic pulse_end;
        bus.wr_frame_end = 1'b1; tick(); bus.wr_frame_end = 1'b0;
    endtask
    task automatic incs(input int n);
        for (int i = 0; i < n; i++) begin
            bus.wr_led_inc = 1'b1; tick(); bus.wr_led_inc = 1'b0;
        end
    endtask
    task automatic latch1;
        bus.disp_latch = 1'b1; tick(); bus.disp_latch = 1'b0;
    endtask
    task automatic frame(input int n);
        pulse_start(); incs(n); pulse_end();
    endtask
    task automatic test_reset;
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        checks++; if (bus.rd_bank !== 1'b0) begin errors++; $display("FAIL reset rd_bank: got %b want 0", bus.rd_bank); end
        checks++; if (bus.wr_bank !== 1'b1) begin errors++; $display("FAIL reset wr_bank: got %b want 1", bus.wr_bank); end
        checks++; if (bus.rd_count !== 4'd0) begin errors++; $display("FAIL reset rd_count: got %0d want 0", bus.rd_count); end
        checks++; if (bus.frame_pending !== 1'b0) begin errors++; $display("FAIL reset pending: got %b want 0", bus.frame_pending); end
        checks++; if (bus.swap_pulse !== 1'b0) begin errors++; $display("FAIL reset swap: got %b want 0", bus.swap_pulse); end
        checks++; if (bus.ovr_count !== 8'd0) begin errors++; $display("FAIL reset ovr: got %0d want 0", bus.ovr_count); end
        checks++; if (bus.wr_allow !== 1'b0) begin errors++; $display("FAIL reset wr_allow: got %b want 0", bus.wr_allow); end
    endtask
    task automatic test_basic;
        pulse_start();
        checks++; if (bus.wr_allow !== 1'b1) begin errors++; $display("FAIL basic wr_allow: got %b want 1", bus.wr_allow); end
        incs(3); pulse_end();
        checks++; if (bus.frame_pending !== 1'b1) begin errors++; $display("FAIL basic pending: got %b want 1", bus.frame_pending); end
        checks++; if (bus.wr_allow !== 1'b0) begin errors++; $display("FAIL basic wr_allow off: got %b want 0", bus.wr_allow); end
        latch1();
        checks++; if (bus.rd_bank !== 1'b1 || bus.wr_bank !== 1'b0) begin errors++; $display("FAIL basic banks: got rd=%b wr=%b want rd=1 wr=0", bus.rd_bank, bus.wr_bank); end
        checks++; if (bus.rd_count !== 4'd3) begin errors++; $display("FAIL basic rd_count: got %0d want 3", bus.rd_count); end
        checks++; if (bus.swap_pulse !== 1'b1) begin errors++; $display("FAIL basic swap: got %b want 1", bus.swap_pulse); end
        checks++; if (bus.frame_pending !== 1'b0) begin errors++; $display("FAIL basic pending clr: got %b want 0", bus.frame_pending); end
        tick();
        checks++; if (bus.swap_pulse !== 1'b0) begin errors++; $display("FAIL basic swap width: got %b want 0", bus.swap_pulse); end
    endtask
    task automatic test_saturate;
        frame(12); latch1();
        checks++; if (bus.rd_count !== 4'd8) begin errors++; $display("FAIL sat rd_count: got %0d want 8", bus.rd_count); end
        checks++; if (bus.rd_bank !== 1'b0) begin errors++; $display("FAIL sat rd_bank: got %b want 0", bus.rd_bank); end
    endtask
    task automatic test_overrun;
        frame(2); pulse_start();
        checks++; if (bus.ovr_count !== 8'd1) begin errors++; $display("FAIL ovr count: got %0d want 1", bus.ovr_count); end
        checks++; if (bus.rd_bank !== 1'b0 || bus.wr_allow !== 1'b1) begin errors++; $display("FAIL ovr drop: got rd=%b allow=%b want rd=0 allow=1", bus.rd_bank, bus.wr_allow); end
        incs(5); pulse_end(); latch1();
        checks++; if (bus.rd_count !== 4'd5) begin errors++; $display("FAIL ovr rd_count: got %0d want 5", bus.rd_count); end
        checks++; if (bus.rd_bank !== 1'b1) begin errors++; $display("FAIL ovr rd_bank: got %b want 1", bus.rd_bank); end
    endtask
    task automatic test_end_latch_same;
        int swaps = 0;
        pulse_start(); incs(5);
        bus.wr_led_inc = 1'b1; bus.wr_frame_end = 1'b1; bus.disp_latch = 1'b1;
        tick();
        bus.wr_led_inc = 1'b0; bus.wr_frame_end = 1'b0;
        checks++; if (bus.frame_pending !== 1'b1 || bus.swap_pulse !== 1'b0 || bus.rd_bank !== 1'b1) begin errors++; $display("FAIL same pend: got pend=%b swap=%b rd=%b want 1 0 1", bus.frame_pending, bus.swap_pulse, bus.rd_bank); end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.swap_pulse === 1'b1) swaps++;
            checks++; if (bus.wr_bank !== ~bus.rd_bank) begin errors++; $display("FAIL same inv: got rd=%b wr=%b", bus.rd_bank, bus.wr_bank); end
        end
        bus.disp_latch = 1'b0;
        checks++; if (swaps !== 1) begin errors++; $display("FAIL same swaps: got %0d want 1", swaps); end
        checks++; if (bus.rd_bank !== 1'b0 || bus.rd_count !== 4'd6) begin errors++; $display("FAIL same result: got rd=%b cnt=%0d want rd=0 cnt=6", bus.rd_bank, bus.rd_count); end
    endtask
    task automatic test_zero_and_ignored;
        pulse_end(); incs(2);
        checks++; if (bus.frame_pending !== 1'b0 || bus.wr_allow !== 1'b0) begin errors++; $display("FAIL idle ignore: got pend=%b allow=%b want 0 0", bus.frame_pending, bus.wr_allow); end
        frame(0); latch1();
        checks++; if (bus.rd_count !== 4'd0 || bus.rd_bank !== 1'b1) begin errors++; $display("FAIL zero frame: got cnt=%0d rd=%b want 0 1", bus.rd_count, bus.rd_bank); end
    endtask
    task automatic test_restart;
        pulse_start(); incs(3); pulse_start(); incs(1); pulse_end();
        bus.wr_frame_end = 1'b1; tick(); bus.wr_frame_end = 1'b0;
        latch1();
        checks++; if (bus.rd_count !== 4'd1 || bus.ovr_count !== 8'd1) begin errors++; $display("FAIL restart: got cnt=%0d ovr=%0d want 1 1", bus.rd_count, bus.ovr_count); end
    endtask
    task automatic test_start_latch_same;
        frame(4);
        bus.wr_frame_start = 1'b1; bus.disp_latch = 1'b1; tick();
        bus.wr_frame_start = 1'b0; bus.disp_latch = 1'b0;
        checks++; if (bus.ovr_count !== 8'd2 || bus.swap_pulse !== 1'b0 || bus.rd_bank !== 1'b0) begin errors++; $display("FAIL start wins: got ovr=%0d swap=%b rd=%b want 2 0 0", bus.ovr_count, bus.swap_pulse, bus.rd_bank); end
        incs(2); pulse_end(); latch1();
        checks++; if (bus.rd_count !== 4'd2 || bus.rd_bank !== 1'b1) begin errors++; $display("FAIL start wins swap: got cnt=%0d rd=%b want 2 1", bus.rd_count, bus.rd_bank); end
    endtask
    task automatic test_rst_mid;
        pulse_start(); incs(2);
        rst = 1'b1; tick(); rst = 1'b0;
        checks++; if (bus.rd_bank !== 1'b0 || bus.wr_bank !== 1'b1 || bus.rd_count !== 4'd0 || bus.ovr_count !== 8'd0 || bus.wr_allow !== 1'b0 || bus.frame_pending !== 1'b0 || bus.swap_pulse !== 1'b0) begin
            errors++; $display("FAIL rst mid: got rd=%b wr=%b cnt=%0d ovr=%0d allow=%b pend=%b want 0 1 0 0 0 0", bus.rd_bank, bus.wr_bank, bus.rd_count, bus.ovr_count, bus.wr_allow, bus.frame_pending);
        end
        pulse_end();
        checks++; if (bus.frame_pending !== 1'b0) begin errors++; $display("FAIL rst end ignored: got %b want 0", bus.frame_pending); end
    endtask
`ifdef NEOPIX_BLANK_TIMEOUT_EN
    task automatic test_timeout;
        frame(4); latch1();
        repeat (99) tick();
        checks++; if (bus.rd_count !== 4'd4) begin errors++; $display("FAIL tmo before: got %0d want 4", bus.rd_count); end
        tick();
        checks++; if (bus.rd_count !== 4'd0) begin errors++; $display("FAIL tmo blank: got %0d want 0", bus.rd_count); end
        frame(3); latch1();
        checks++; if (bus.rd_count !== 4'd3) begin errors++; $display("FAIL tmo restore: got %0d want 3", bus.rd_count); end
    endtask
`endif
    initial begin
        bus.wr_frame_start = 1'b0;
        bus.wr_frame_end   = 1'b0;
        bus.wr_led_inc     = 1'b0;
        bus.disp_latch     = 1'b0;
        test_reset();
        test_basic();
        test_saturate();
        test_overrun();
        test_end_latch_same();
        test_zero_and_ignored();
        test_restart();
        test_start_latch_same();
        test_rst_mid();
`ifdef NEOPIX_BLANK_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/neopix_bank_ctrl.md
Name: neopix_bank_ctrl

Overview:
- Scheduler for the double-buffered LED frame RAM shared between the SPI frame writer and the ws2812 serializer.
- Decides which bank each side owns and counts LEDs written per frame.
- Swaps banks only inside the serializer's latch/reset gap, so a frame is never displayed half-old/half-new.
- Sits between the SPI receive front end, the dual-port RAM bank-select bits and the ws2812 driver.

Parameters:
- NUM_LEDS, 8, LEDs per bank; the RAM holds 2*NUM_LEDS words.
- CNT_W, $clog2(NUM_LEDS)+1, width of LED count values.
- OVR_W, 8, width of the dropped-frame counter.
- TIMEOUT_CYCLES, 50000000, idle cycles before blanking (optional feature only).

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous, active-high reset
- wr_frame_start  in  1  one-cycle pulse: SSEL falling edge, new SPI frame begins
- wr_frame_end  in  1  one-cycle pulse: SSEL rising edge, SPI frame ends
- wr_led_inc  in  1  one-cycle pulse: one complete 24-bit LED word written to RAM
- disp_latch  in  1  level from ws2812 reset_state: high during the latch gap
- wr_bank  out  1  bank the SPI writer must address (back bank)
- wr_allow  out  1  high while the writer may assert RAM wren
- rd_bank  out  1  bank the serializer reads (front bank)
- rd_count  out  CNT_W  number of valid LEDs in the front bank; addresses >= rd_count are sent as black
- frame_pending  out  1  a complete frame waits for the next swap
- swap_pulse  out  1  one-cycle pulse in the cycle after a swap
- ovr_count  out  OVR_W  frames dropped before display; saturating

Behaviour:
- Reset values: state IDLE, rd_bank=0, wr_bank=1, rd_count=0, wr_cnt=0, frame_pending=0, swap_pulse=0, ovr_count=0, wr_allow=0.
- Invariant: wr_bank == ~rd_bank in every cycle; both are registered.
- States:
  - IDLE → WRITING on wr_frame_start; wr_cnt cleared.
  - WRITING: wr_allow=1. wr_led_inc increments wr_cnt, saturating at NUM_LEDS. wr_frame_end → PENDING, wr_cnt held.
  - PENDING: frame_pending=1, wr_allow=0. In any cycle with disp_latch=1: rd_bank<=wr_bank, wr_bank<=rd_bank, rd_count<=wr_cnt, state → IDLE, swap_pulse=1 next cycle. The new bank is visible one cycle after the sampled latch cycle.
- wr_frame_start while PENDING: the pending frame is dropped; ovr_count+1 (saturating); wr_cnt cleared; state → WRITING in the same back bank. The front bank is untouched.
- wr_frame_start while WRITING (end edge missed): restart; wr_cnt cleared; no overrun.
- wr_frame_end in IDLE or PENDING: ignored.
- wr_frame_end and wr_led_inc in the same cycle: the increment is counted before the value is latched for display.
- wr_frame_end and disp_latch in the same cycle: enter PENDING only; the swap happens on a later cycle if disp_latch is still high.
- wr_frame_start and disp_latch in the same cycle while PENDING: the start wins (drop and overrun).
- Zero-LED frame: swaps normally; rd_count=0, so the strip shows black.
- wr_led_inc outside WRITING: ignored.
- RST mid-frame: return to reset values at the next edge; RAM contents are not cleared.

Optional Feature:
- Macro: NEOPIX_BLANK_TIMEOUT_EN.
- Defined: a counter of width $clog2(TIMEOUT_CYCLES+1) is cleared on every swap and on RST, and increments otherwise. On reaching TIMEOUT_CYCLES, rd_count is forced to 0 (strip blanks) and the counter holds until the next swap.
- Undefined: no counter is built; rd_count changes only on swap or RST.

Decomposition:
- Package neopix_pkg: state enum (IDLE, WRITING, PENDING), NUM_LEDS default, CNT_W derivation function, RAM word layout constants (G[23:16], R[15:8], B[7:0]).
- One natural sub-module: neopix_sat_counter (parameterised width, inc/clear/saturate), used for wr_cnt, ovr_count and the timeout counter.

Test Plan:
- RST, then start; 3 inc; end; disp_latch=1 for 1 cycle → rd_bank=1, wr_bank=0, rd_count=3, swap_pulse high exactly 1 cycle, frame_pending=0.
- Start; 12 inc with NUM_LEDS=8; end; latch → rd_count=8 (saturated).
- Start; 2 inc; end; second start before any latch; 5 inc; end; latch → ovr_count=1, rd_count=5, a single bank toggle.
- wr_frame_end and disp_latch in the same cycle, latch held 4 cycles → swap 1 cycle later; wr_bank==~rd_bank checked every cycle.
- RST asserted mid-WRITING after 2 inc → all outputs equal reset values next cycle; a subsequent end is ignored.
- With NEOPIX_BLANK_TIMEOUT_EN and TIMEOUT_CYCLES=100: swap with count 4, no further frames → rd_count=0 at cycle 100 after the swap; a new frame swap restores the new count.
